// File: rtl/keypoint_frame_seq.sv
// ============================================================================
// Module   : keypoint_frame_seq
// Brief    : Frame sequencer: loads an image into RAM, scans it through the
//            DoG pipeline, and reports keypoint coordinates.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypoint_frame_seq #(
   parameter int IMG_W    = 256,
   parameter int IMG_H    = 256,
   parameter int PIPE_LAT = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        load_valid,
   input  logic [7:0]  load_data,
   output logic        load_ready,
   output logic        ram_we,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_din,
   output logic        scan_en,
   input  logic        keypoint,
   output logic        kp_valid,
   output logic [7:0]  kp_x,
   output logic [7:0]  kp_y,
   output logic [15:0] kp_count,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SCAN  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int          c_total      = IMG_W * IMG_H;
   localparam logic [15:0] c_last_px    = 16'(c_total - 1);
   localparam logic [4:0]  c_last_drain = 5'(PIPE_LAT - 1);
   localparam logic [7:0]  c_last_x     = 8'(IMG_W - 1);

   state_t                r_state;
   logic [15:0]           r_wr_cnt;
   logic [15:0]           r_scan_cnt;
   logic [4:0]            r_drain_cnt;
   logic [PIPE_LAT-1:0]   r_qual_sr;
   logic [PIPE_LAT-1:0]   w_qual_next;
   logic [7:0]            r_ox;
   logic [7:0]            r_oy;
   logic                  r_load_ready;
   logic                  r_scan_en;
   logic                  r_kp_valid;
   logic [7:0]            r_kp_x;
   logic [7:0]            r_kp_y;
   logic [15:0]           r_kp_count;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_accept;
   logic                  w_qual;

   assign w_accept = load_valid & r_load_ready;
   // qual marks the cycle where the keypoint matching a scan_en cycle arrives
   assign w_qual   = r_qual_sr[PIPE_LAT-1];

   always_comb begin
      w_qual_next    = r_qual_sr << 1;
      w_qual_next[0] = r_scan_en;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_wr_cnt     <= 16'd0;
         r_scan_cnt   <= 16'd0;
         r_drain_cnt  <= 5'd0;
         r_qual_sr    <= '0;
         r_ox         <= 8'd0;
         r_oy         <= 8'd0;
         r_load_ready <= 1'b0;
         r_scan_en    <= 1'b0;
         r_kp_valid   <= 1'b0;
         r_kp_x       <= 8'd0;
         r_kp_y       <= 8'd0;
         r_kp_count   <= 16'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_qual_sr  <= w_qual_next;
         r_kp_valid <= 1'b0;

         if (w_qual) begin
            if (keypoint) begin
               r_kp_valid <= 1'b1;
               r_kp_x     <= r_ox;
               r_kp_y     <= r_oy;
               if (r_kp_count != 16'hFFFF)
                  r_kp_count <= r_kp_count + 16'd1;
            end
            if (r_ox == c_last_x) begin
               r_ox <= 8'd0;
               r_oy <= r_oy + 8'd1;
            end else begin
               r_ox <= r_ox + 8'd1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state      <= S_LOAD;
                  r_load_ready <= 1'b1;
                  r_busy       <= 1'b1;
                  r_wr_cnt     <= 16'd0;
                  r_scan_cnt   <= 16'd0;
                  r_drain_cnt  <= 5'd0;
                  r_ox         <= 8'd0;
                  r_oy         <= 8'd0;
                  r_kp_count   <= 16'd0;
               end
            end
            S_LOAD: begin
               // the counter stops on the last pixel so ram_addr keeps the final write address
               if (w_accept) begin
                  if (r_wr_cnt == c_last_px) begin
                     r_state      <= S_SCAN;
                     r_load_ready <= 1'b0;
                     r_scan_en    <= 1'b1;
                     r_scan_cnt   <= 16'd0;
                  end else begin
                     r_wr_cnt <= r_wr_cnt + 16'd1;
                  end
               end
            end
            S_SCAN: begin
               if (r_scan_cnt == c_last_px) begin
                  r_state     <= S_DRAIN;
                  r_scan_en   <= 1'b0;
                  r_drain_cnt <= 5'd0;
               end else begin
                  r_scan_cnt <= r_scan_cnt + 16'd1;
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == c_last_drain) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 5'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state      <= S_IDLE;
               r_load_ready <= 1'b0;
               r_scan_en    <= 1'b0;
               r_done       <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign load_ready = r_load_ready;
   assign ram_we     = w_accept;
   assign ram_addr   = r_wr_cnt;
   assign ram_din    = r_load_ready ? load_data : 8'h00;
   assign scan_en    = r_scan_en;
   assign kp_valid   = r_kp_valid;
   assign kp_x       = r_kp_x;
   assign kp_y       = r_kp_y;
   assign kp_count   = r_kp_count;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_keypoint_frame_seq.sv
// ============================================================================
// Module   : tb_keypoint_frame_seq
// Brief    : Directed self-checking bench for keypoint_frame_seq (4x3, lat 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_keypoint_frame_seq;

   localparam int c_w   = 4;
   localparam int c_h   = 3;
   localparam int c_lat = 3;
   localparam int c_n   = c_w * c_h;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        load_valid = 1'b0;
   logic [7:0]  load_data = 8'h00;
   logic        keypoint = 1'b0;
   logic        load_ready, ram_we, scan_en, kp_valid, busy, done;
   logic [15:0] ram_addr, kp_count;
   logic [7:0]  ram_din, kp_x, kp_y;

   always #5 clk = ~clk;

   keypoint_frame_seq #(.IMG_W(c_w), .IMG_H(c_h), .PIPE_LAT(c_lat)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .scan_en    (scan_en),
      .keypoint   (keypoint),
      .kp_valid   (kp_valid),
      .kp_x       (kp_x),
      .kp_y       (kp_y),
      .kp_count   (kp_count),
      .busy       (busy),
      .done       (done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Mid-cycle observer: collects writes, scan/done timing and keypoint reports.
   int         cyc = 0;
   logic [15:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   logic [7:0]  kp_xs[$];
   logic [7:0]  kp_ys[$];
   int scan_n, scan_runs, done_n, kp_with_done, qidx;
   int first_wr_cyc, last_wr_cyc, first_scan_cyc, last_scan_cyc, done_cyc;
   logic prev_scan = 1'b0;
   logic [2:0] hist = 3'b000;
   logic q;
   bit kp_mode = 1'b0;
   bit kp_noise = 1'b0;

   always @(negedge clk) begin
      cyc++;
      // keypoint for this cycle follows scan_en from c_lat cycles earlier
      q = hist[2];
      if (q) qidx++;
      if (kp_mode && q) keypoint = (qidx == 1) || (qidx == 6) || (qidx == 12);
      else              keypoint = kp_noise && !q;
      hist = rst ? {hist[1:0], scan_en} : 3'b000;
      if (ram_we) begin
         if (wr_addr.size() == 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         wr_addr.push_back(ram_addr);
         wr_data.push_back(ram_din);
      end
      if (scan_en) begin
         if (!prev_scan) begin
            scan_runs++;
            first_scan_cyc = cyc;
         end
         scan_n++;
         last_scan_cyc = cyc;
      end
      prev_scan = scan_en;
      if (done) begin
         done_n++;
         done_cyc = cyc;
      end
      if (kp_valid) begin
         kp_xs.push_back(kp_x);
         kp_ys.push_back(kp_y);
         if (done) kp_with_done++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      wr_addr.delete();
      wr_data.delete();
      kp_xs.delete();
      kp_ys.delete();
      scan_n = 0; scan_runs = 0; done_n = 0; kp_with_done = 0; qidx = 0;
      first_wr_cyc = 0; last_wr_cyc = 0; first_scan_cyc = 0; last_scan_cyc = 0; done_cyc = 0;
   endtask

   task automatic start_and_load(input bit gaps);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < c_n; i++) begin
         if (gaps) begin
            load_valid = 1'b0;
            tick();
         end
         load_valid = 1'b1;
         load_data  = 8'(8'h10 + i);
         tick();
      end
      load_valid = 1'b0;
   endtask

   task automatic run_frame(input bit gaps, input bit start_in_scan);
      bit pulsed;
      pulsed = 1'b0;
      clear_mon();
      start_and_load(gaps);
      for (int k = 0; k < 40; k++) begin
         start = start_in_scan && scan_en && !pulsed && (k > 2);
         if (start) pulsed = 1'b1;
         tick();
      end
      start = 1'b0;
   endtask

   task automatic frame_checks(input string tag, input int wr_span);
      check_val({tag, "_wr_n"}, wr_addr.size(), c_n);
      for (int i = 0; i < wr_addr.size(); i++) begin
         check_val({tag, "_addr"}, wr_addr[i], i);
         check_val({tag, "_data"}, wr_data[i], 8'h10 + i);
      end
      check_val({tag, "_wr_span"}, last_wr_cyc - first_wr_cyc, wr_span);
      check_val({tag, "_scan_n"}, scan_n, c_n);
      check_val({tag, "_scan_runs"}, scan_runs, 1);
      check_val({tag, "_scan_after_load"}, first_scan_cyc - last_wr_cyc, 1);
      check_val({tag, "_done_n"}, done_n, 1);
      check_val({tag, "_drain_gap"}, done_cyc - last_scan_cyc, c_lat + 1);
      check_val({tag, "_busy_after"}, busy, 0);
      check_val({tag, "_ready_after"}, load_ready, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      clear_mon();
      // Reset with loader driving, so ram_we/ram_din must still read 0
      rst = 1'b0;
      load_valid = 1'b1;
      load_data  = 8'hA5;
      start = 1'b1;
      tick();
      tick();
      check_val("rst_ctrl", {load_ready, ram_we, scan_en, kp_valid, busy, done}, 0);
      check_val("rst_addr", ram_addr, 0);
      check_val("rst_din", ram_din, 0);
      check_val("rst_kpxy", {kp_x, kp_y}, 0);
      check_val("rst_kpcnt", kp_count, 0);
      start = 1'b0;
      load_valid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      tick();
      check_val("idle_ctrl", {load_ready, ram_we, scan_en, kp_valid, busy, done}, 0);
      check_val("idle_addr", ram_addr, 0);

      // Back-to-back frame
      run_frame(1'b0, 1'b0);
      frame_checks("f1", c_n - 1);
      check_val("f1_last_addr_held", ram_addr, c_n - 1);

      // Loader with bubbles
      run_frame(1'b1, 1'b0);
      frame_checks("gap", 2 * (c_n - 1));

      // Keypoints on qual 1, 6, 12; keypoint asserted on every non-qual cycle too
      kp_mode  = 1'b1;
      kp_noise = 1'b1;
      run_frame(1'b0, 1'b0);
      kp_mode  = 1'b0;
      kp_noise = 1'b0;
      frame_checks("kp", c_n - 1);
      check_val("kp_reports", kp_xs.size(), 3);
      if (kp_xs.size() == 3) begin
         check_val("kp0_xy", {kp_xs[0], kp_ys[0]}, {8'd0, 8'd0});
         check_val("kp1_xy", {kp_xs[1], kp_ys[1]}, {8'd1, 8'd1});
         check_val("kp2_xy", {kp_xs[2], kp_ys[2]}, {8'd3, 8'd2});
      end
      check_val("kp_count", kp_count, 3);
      check_val("kp_last_with_done", kp_with_done, 1);
      check_val("kp_xy_hold", {kp_x, kp_y}, {8'd3, 8'd2});

      // Reset in the 5th scan_en cycle
      clear_mon();
      start_and_load(1'b0);
      sc = 0;
      for (int k = 0; k < 30; k++) begin
         if (scan_en) sc++;
         if (sc == 5) break;
         tick();
      end
      check_val("abort_reached_scan5", sc, 5);
      rst = 1'b0;
      tick();
      check_val("abort_state", {busy, scan_en, done, load_ready}, 0);
      check_val("abort_kpcnt", kp_count, 0);
      rst = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      check_val("abort_no_done", done_n, 0);
      check_val("abort_scan_n", scan_n, 5);
      check_val("abort_idle", busy, 0);
      run_frame(1'b0, 1'b0);
      frame_checks("post_abort", c_n - 1);

      // start pulsed during SCAN must not retrigger
      run_frame(1'b0, 1'b1);
      frame_checks("start_in_scan", c_n - 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
